// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: registered PC, next-PC selection and imem fetch handshake.
// Optional build macro PC_MISALIGN_CHECK_EN turns misaligned redirects into traps.
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter int               INC          = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_inc_o,
    output logic [CNT_W-1:0] fetch_count_o,
    output logic             misalign_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_pc_plus_inc;
    logic [XLEN-1:0]  w_target;
    logic [CNT_W-1:0] r_count;
    logic             r_misalign;
    logic             w_misalign;
    logic             w_take_trap;
    logic             w_valid;
    logic             w_fire;

    assign w_valid       = (r_state == S_RUN);
    assign w_fire        = w_valid & fetch_ready_i;
    assign w_pc_plus_inc = r_pc + XLEN'(INC);

`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned redirect becomes a trap; an explicit trap in the same cycle suppresses the flag.
    assign w_misalign = redirect_i & (redirect_target_i[1:0] != 2'b00) & ~trap_i;
    assign w_target   = redirect_target_i;
`else
    assign w_misalign = 1'b0;
    assign w_target   = redirect_target_i & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    assign w_take_trap = trap_i | w_misalign;

    // Next-state and next-PC selection: trap > redirect > sequential advance > hold.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            S_BOOT:  w_next_state = S_RUN;
            S_RUN:   w_next_state = S_RUN;
            S_FLUSH: w_next_state = S_RUN;
            default: w_next_state = S_BOOT;
        endcase
        if (w_take_trap) begin
            w_next_pc    = TRAP_VECTOR;
            w_next_state = S_FLUSH;
        end else if (redirect_i) begin
            w_next_pc    = w_target;
        end else if (w_fire && !stall_i) begin
            w_next_pc    = w_pc_plus_inc;
        end else begin
            w_next_pc    = r_pc;
        end
    end

    // State, PC, accepted-fetch counter and misalign pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_count    <= {CNT_W{1'b0}};
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= w_misalign;
            if (w_fire) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign fetch_valid_o = w_valid;
    assign pc_o          = r_pc;
    assign pc_plus_inc_o = w_pc_plus_inc;
    assign fetch_count_o = r_count;
    assign misalign_o    = r_misalign;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the rv32im fetch stage; supersedes the combinational pc_adder.
- Holds the architectural fetch PC in a register and computes PC+INC internally.
- Selects the next PC from sequential advance, branch/jump redirect or trap vector.
- Issues fetch requests to instruction memory over a valid/ready handshake; counts accepted fetches.

Parameters:
- XLEN, 32, address/PC width in bits
- INC, 4, sequential increment in bytes
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
- CNT_W, 16, width of fetch counter

Ports:
- clk, input, 1, core clock; all state updates on rising edge
- rst_n, input, 1, synchronous active-low reset
- stall_i, input, 1, hold PC; no advance
- redirect_i, input, 1, branch/jump taken this cycle
- redirect_target_i, input, XLEN, redirect destination
- trap_i, input, 1, exception/interrupt entry request
- fetch_ready_i, input, 1, imem accepts request
- fetch_valid_o, output, 1, fetch request valid
- pc_o, output, XLEN, current fetch PC (registered)
- pc_plus_inc_o, output, XLEN, pc_o + INC (combinational from pc_o)
- fetch_count_o, output, CNT_W, number of accepted fetches
- misalign_o, output, 1, misaligned redirect pulse (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge): pc_o=RESET_VECTOR, fetch_valid_o=0, fetch_count_o=0, misalign_o=0, state=S_BOOT. Reset mid-operation discards any pending request or redirect with no exception.
- States:
  - S_BOOT: fetch_valid_o=0; next state S_RUN unconditionally.
  - S_RUN: fetch_valid_o=1.
  - S_FLUSH: fetch_valid_o=0; next state S_RUN.
- Handshake: fire = fetch_valid_o & fetch_ready_i.
  - fetch_valid_o and pc_o stay stable while fetch_ready_i=0.
  - Only redirect, trap or reset may withdraw an unaccepted request (flush semantics).
- Next-PC priority, evaluated in S_RUN, highest first:
  1. trap_i: pc_o<=TRAP_VECTOR, state<=S_FLUSH (one bubble cycle).
  2. redirect_i: pc_o<=redirect_target_i, stay in S_RUN, no bubble.
  3. fire & !stall_i: pc_o<=pc_o+INC.
  4. Otherwise: hold.
- trap_i and redirect_i in S_BOOT/S_FLUSH: same PC load as above; state transitions per the table; trap from S_FLUSH re-enters S_FLUSH.
- stall_i has no effect on trap or redirect; both override stall.
- fetch_count_o increments by 1 on every fire, including a fire in the same cycle as stall/redirect/trap (the request was accepted). Wraps modulo 2^CNT_W.
- Arithmetic: pc_o+INC truncated to XLEN bits. Wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Latency: all PC loads visible on pc_o the cycle after the causing input; pc_plus_inc_o follows pc_o in the same cycle.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN
- Defined: redirect_i with redirect_target_i[1:0]!=2'b00 is treated as a trap.
  - pc_o<=TRAP_VECTOR, state<=S_FLUSH.
  - misalign_o=1 for exactly the following cycle; target discarded.
  - An explicit trap_i in the same cycle still wins; misalign_o stays 0.
- Undefined: redirect_target_i[1:0] forced to 2'b00 on load; misalign_o tied 0.

Test Plan:
- Reset/boot: hold rst_n=0 two cycles, release, fetch_ready_i=1 -> fetch_valid_o 0 for one cycle (S_BOOT), then pc_o=0,4,8,C on successive cycles; fetch_count_o=1,2,3.
- Backpressure + stall: pc_o=8, fetch_ready_i=0 for 3 cycles, then stall_i=1 with ready=1 -> pc_o holds 8 throughout; fetch_count_o increments only during the stalled ready cycle.
- Redirect vs trap: redirect_i=1 (target 32'h40) alone -> pc_o=40 next cycle, no bubble. redirect_i=1 and trap_i=1 together -> pc_o=100, one cycle fetch_valid_o=0, then 100, 104.
- Wrap-around: force pc_o=32'hFFFF_FFFC via redirect, ready=1 -> next pc_o=0, pc_plus_inc_o=4.
- Misalign (PC_MISALIGN_CHECK_EN defined): redirect target 32'h42 -> pc_o=100, misalign_o one-cycle pulse. Undefined: same stimulus -> pc_o=40, misalign_o=0.
- Reset mid-run: rst_n=0 while pc_o=104 and fetch_ready_i=0 -> next cycle pc_o=0, fetch_valid_o=0, fetch_count_o=0.
